// File: rtl/rgmii_idelay_tap_ctrl.sv
// Runtime tap controller for a bank of VAR_LOAD IDELAYE2 lanes (RGMII RXD/RCTL/RXCLK).
// Define IDELAY_TAP_VERIFY_EN to compare CNTVALUEOUT against the shadow tap after each load.
module rgmii_idelay_tap_ctrl #(
    parameter int CHANNELS   = 6,
    parameter int TAP_W      = 5,
    parameter int DATA_TAP   = 25,
    parameter int CLK_TAP    = 0,
    parameter int CLK_CHAN   = 5,
    parameter int SETTLE_CYC = 4,
    localparam int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      delay_clk,
    input  logic                      delay_rst,
    input  logic                      rdy_in,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    input  logic [1:0]                cfg_op,
    input  logic [CH_W-1:0]           cfg_chan,
    input  logic [TAP_W-1:0]          cfg_tap,
    output logic [CHANNELS*TAP_W-1:0] idelay_cntvaluein,
    output logic [CHANNELS-1:0]       idelay_ld,
    input  logic [CHANNELS*TAP_W-1:0] idelay_cntvalueout,
    output logic                      rd_valid,
    output logic [TAP_W-1:0]          rd_tap,
    output logic                      init_done,
    output logic                      busy,
    output logic                      err,
    output logic [1:0]                err_code,
    output logic [CH_W-1:0]           err_chan
);

    localparam int SC_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    localparam logic [1:0] OP_SET  = 2'b00;
    localparam logic [1:0] OP_INC  = 2'b01;
    localparam logic [1:0] OP_READ = 2'b11;

    typedef enum logic [2:0] {WAIT_RDY, INIT, IDLE, LOAD, SETTLE, VERIFY} state_t;

    state_t           state, next_state;
    logic             rdy_p0, rdy_p1, rdy_p2;
    logic [TAP_W-1:0] shadow [CHANNELS];
    logic [CH_W-1:0]  lane;
    logic [SC_W-1:0]  settle_cnt;
    logic             in_init;
    logic             accept, chan_ok, settle_last, last_lane, rdy_lost, lane_done;
    state_t           after_lane;

    function automatic logic [TAP_W-1:0] sat_inc(input logic [TAP_W-1:0] t);
        return (t == {TAP_W{1'b1}}) ? t : t + TAP_W'(1);
    endfunction

    function automatic logic [TAP_W-1:0] sat_dec(input logic [TAP_W-1:0] t);
        return (t == '0) ? t : t - TAP_W'(1);
    endfunction

    function automatic logic [TAP_W-1:0] default_tap(input int k);
        return (k == CLK_CHAN) ? TAP_W'(CLK_TAP) : TAP_W'(DATA_TAP);
    endfunction

    for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
        assign idelay_cntvaluein[k*TAP_W +: TAP_W] = shadow[k];
    end

`ifdef IDELAY_TAP_VERIFY_EN
    logic [TAP_W-1:0] tap_out [CHANNELS];
    for (genvar k = 0; k < CHANNELS; k++) begin : g_readback
        assign tap_out[k] = idelay_cntvalueout[k*TAP_W +: TAP_W];
    end
`else
    logic unused_cntvalueout;
    assign unused_cntvalueout = ^idelay_cntvalueout;
`endif

    // Stage p0..p2: RDY synchroniser plus one history flop for the two-cycle qualification
    always_ff @(posedge delay_clk) begin
        if (delay_rst) begin
            rdy_p0 <= 1'b0;
            rdy_p1 <= 1'b0;
            rdy_p2 <= 1'b0;
        end else begin
            rdy_p0 <= rdy_in;
            rdy_p1 <= rdy_p0;
            rdy_p2 <= rdy_p1;
        end
    end

    assign accept      = cfg_valid && (state == IDLE);
    assign chan_ok     = int'(cfg_chan) < CHANNELS;
    assign settle_last = (settle_cnt == SC_W'(SETTLE_CYC - 1));
    assign last_lane   = (lane == CH_W'(CHANNELS - 1));
    assign rdy_lost    = (state != WAIT_RDY) && !rdy_p1;
    assign after_lane  = (in_init && !last_lane) ? INIT : IDLE;
`ifdef IDELAY_TAP_VERIFY_EN
    assign lane_done   = (state == VERIFY) && !rdy_lost;
`else
    assign lane_done   = (state == SETTLE) && settle_last && !rdy_lost;
`endif

    always_ff @(posedge delay_clk) begin
        if (delay_rst) state <= WAIT_RDY;
        else           state <= next_state;
    end

    always_comb begin
        next_state = state;
        cfg_ready  = 1'b0;
        busy       = 1'b1;
        idelay_ld  = '0;
        case (state)
            WAIT_RDY: if (rdy_p1 && rdy_p2) next_state = INIT;
            INIT:     next_state = LOAD;
            IDLE: begin
                cfg_ready = 1'b1;
                busy      = 1'b0;
                if (accept && chan_ok && cfg_op != OP_READ) next_state = LOAD;
            end
            LOAD: begin
                idelay_ld  = CHANNELS'(1) << lane;
                next_state = SETTLE;
            end
`ifdef IDELAY_TAP_VERIFY_EN
            SETTLE:   if (settle_last) next_state = VERIFY;
            VERIFY:   next_state = after_lane;
`else
            SETTLE:   if (settle_last) next_state = after_lane;
`endif
            default:  next_state = WAIT_RDY;
        endcase
        // Losing RDY aborts whatever is in flight, including a LOAD strobe this cycle
        if (rdy_lost) begin
            next_state = WAIT_RDY;
            idelay_ld  = '0;
        end
    end

    always_ff @(posedge delay_clk) begin
        if (delay_rst) begin
            for (int k = 0; k < CHANNELS; k++) shadow[k] <= default_tap(k);
            lane       <= '0;
            settle_cnt <= '0;
            in_init    <= 1'b0;
            init_done  <= 1'b0;
            rd_valid   <= 1'b0;
            err        <= 1'b0;
            err_code   <= 2'b00;
            err_chan   <= '0;
        end else begin
            rd_valid   <= 1'b0;
            settle_cnt <= (state == SETTLE) ? settle_cnt + SC_W'(1) : '0;
            if (state == WAIT_RDY && next_state == INIT) begin
                lane    <= '0;
                in_init <= 1'b1;
            end
            if (accept) begin
                if (!chan_ok) begin
                    if (!err) begin
                        err      <= 1'b1;
                        err_code <= 2'b01;
                        err_chan <= cfg_chan;
                    end
                end else if (cfg_op == OP_READ) begin
                    rd_valid <= 1'b1;
                end else begin
                    lane <= cfg_chan;
                    case (cfg_op)
                        OP_SET:  shadow[cfg_chan] <= cfg_tap;
                        OP_INC:  shadow[cfg_chan] <= sat_inc(shadow[cfg_chan]);
                        default: shadow[cfg_chan] <= sat_dec(shadow[cfg_chan]);
                    endcase
                end
            end
`ifdef IDELAY_TAP_VERIFY_EN
            if (lane_done && tap_out[lane] != shadow[lane] && !err) begin
                err      <= 1'b1;
                err_code <= 2'b10;
                err_chan <= lane;
            end
`endif
            if (lane_done && in_init) begin
                if (last_lane) begin
                    init_done <= 1'b1;
                    in_init   <= 1'b0;
                end else begin
                    lane <= lane + CH_W'(1);
                end
            end
            if (rdy_lost) init_done <= 1'b0;
        end
    end

    always_ff @(posedge delay_clk) begin
        if (accept && chan_ok && cfg_op == OP_READ) rd_tap <= shadow[cfg_chan];
    end

endmodule

// File: tb/tb_rgmii_idelay_tap_ctrl.sv
// Scoreboard bench for rgmii_idelay_tap_ctrl: expected LD pulses and read responses are
// queued by the stimulus and matched by an independent monitor; status is checked directly.
module tb_rgmii_idelay_tap_ctrl;
    localparam int CHANNELS   = 6;
    localparam int TAP_W      = 5;
    localparam int SETTLE_CYC = 4;
    localparam int CH_W       = 3;
`ifdef IDELAY_TAP_VERIFY_EN
    localparam int EXP_LAT    = SETTLE_CYC + 3;
`else
    localparam int EXP_LAT    = SETTLE_CYC + 2;
`endif

    localparam logic [1:0] OP_SET  = 2'b00;
    localparam logic [1:0] OP_INC  = 2'b01;
    localparam logic [1:0] OP_DEC  = 2'b10;
    localparam logic [1:0] OP_READ = 2'b11;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      rdy_in;
    logic                      cfg_valid;
    logic                      cfg_ready;
    logic [1:0]                cfg_op;
    logic [CH_W-1:0]           cfg_chan;
    logic [TAP_W-1:0]          cfg_tap;
    logic [CHANNELS*TAP_W-1:0] cntvaluein;
    logic [CHANNELS*TAP_W-1:0] cntvalueout;
    logic [CHANNELS*TAP_W-1:0] cvo_reg;
    logic [CHANNELS-1:0]       ld;
    logic                      rd_valid;
    logic [TAP_W-1:0]          rd_tap;
    logic                      init_done;
    logic                      busy;
    logic                      err;
    logic [1:0]                err_code;
    logic [CH_W-1:0]           err_chan;
    logic                      hold3;

    typedef struct {
        int lane;
        int tap;
    } ld_exp_t;

    ld_exp_t ld_q[$];
    int      rd_q[$];
    int      n_chk  = 0;
    int      n_fail = 0;
    ld_exp_t mon_e;
    int      mon_lane;

    always #5 clk = ~clk;

    rgmii_idelay_tap_ctrl #(
        .CHANNELS(CHANNELS), .TAP_W(TAP_W), .DATA_TAP(25), .CLK_TAP(0),
        .CLK_CHAN(5), .SETTLE_CYC(SETTLE_CYC)
    ) dut (
        .delay_clk(clk), .delay_rst(rst), .rdy_in(rdy_in),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_op(cfg_op),
        .cfg_chan(cfg_chan), .cfg_tap(cfg_tap),
        .idelay_cntvaluein(cntvaluein), .idelay_ld(ld),
        .idelay_cntvalueout(cntvalueout),
        .rd_valid(rd_valid), .rd_tap(rd_tap), .init_done(init_done),
        .busy(busy), .err(err), .err_code(err_code), .err_chan(err_chan)
    );

    // IDELAYE2 VAR_LOAD model: CNTVALUEOUT follows CNTVALUEIN on LD; lane 3 can be stuck at 0
    always @(posedge clk) begin
        if (rst) cvo_reg <= '0;
        else
            for (int k = 0; k < CHANNELS; k++)
                if (ld[k]) cvo_reg[k*TAP_W +: TAP_W] <= cntvaluein[k*TAP_W +: TAP_W];
    end

    always_comb begin
        cntvalueout = cvo_reg;
        if (hold3) cntvalueout[3*TAP_W +: TAP_W] = '0;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: bound expired", name);
    endtask

    function automatic int pack_taps(input int t[CHANNELS]);
        logic [CHANNELS*TAP_W-1:0] v;
        for (int k = 0; k < CHANNELS; k++) v[k*TAP_W +: TAP_W] = TAP_W'(t[k]);
        return int'(v);
    endfunction

    task automatic push_ld(input int lane, input int tap);
        ld_exp_t e;
        e.lane = lane;
        e.tap  = tap;
        ld_q.push_back(e);
    endtask

    task automatic push_init(input int t[CHANNELS]);
        for (int k = 0; k < CHANNELS; k++) push_ld(k, t[k]);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (ld != '0) begin
                mon_lane = -1;
                for (int k = CHANNELS - 1; k >= 0; k--) if (ld[k]) mon_lane = k;
                chk("ld_onehot", $countones(ld), 1);
                if (ld_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL ld_unexpected: lane %0d pulsed, none required", mon_lane);
                end else begin
                    mon_e = ld_q.pop_front();
                    chk("ld_lane", mon_lane, mon_e.lane);
                    chk("ld_tap", int'(cntvaluein[mon_lane*TAP_W +: TAP_W]), mon_e.tap);
                end
            end
            if (rd_valid) begin
                if (rd_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL rd_unexpected: rd_tap %0d, no read required", rd_tap);
                end else begin
                    chk("rd_tap", int'(rd_tap), rd_q.pop_front());
                end
            end
        end
    end

    task automatic send(input logic [1:0] op, input int chan, input int tap);
        int t;
        t = 0;
        @(negedge clk);
        cfg_valid = 1'b1;
        cfg_op    = op;
        cfg_chan  = CH_W'(chan);
        cfg_tap   = TAP_W'(tap);
        while (!cfg_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!cfg_ready) begin
            fail_now("cfg_ready_wait");
            cfg_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1 cfg_valid = 1'b0;
        end
    endtask

    task automatic send_read2(input int a, input int b);
        @(negedge clk);
        cfg_valid = 1'b1;
        cfg_op    = OP_READ;
        cfg_chan  = CH_W'(a);
        if (!cfg_ready) begin
            fail_now("read2_ready");
            cfg_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1 cfg_chan = CH_W'(b);
            @(posedge clk);
            #1 cfg_valid = 1'b0;
        end
    endtask

    task automatic wait_idle(output int lat);
        int edges;
        edges = 0;
        lat   = 0;
        while (1) begin
            @(posedge clk);
            #1 edges++;
            if (!busy) begin
                lat = edges + 1;
                break;
            end
            if (edges >= 200) begin
                fail_now("busy_wait");
                break;
            end
        end
    endtask

    task automatic wait_init();
        int edges;
        edges = 0;
        while (1) begin
            @(posedge clk);
            #1 edges++;
            if (init_done) break;
            if (edges >= 400) begin
                fail_now("init_wait");
                break;
            end
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int def_taps[CHANNELS]    = '{25, 25, 25, 25, 25, 0};
        int mid_taps[CHANNELS]    = '{0, 31, 7, 25, 25, 0};
        int reload_taps[CHANNELS] = '{25, 25, 25, 12, 17, 0};

        rst = 1'b1; rdy_in = 1'b0; cfg_valid = 1'b0; cfg_op = 2'b00;
        cfg_chan = '0; cfg_tap = '0; hold3 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ld", int'(ld), 0);
        chk("rst_cfg_ready", int'(cfg_ready), 0);
        chk("rst_rd_valid", int'(rd_valid), 0);
        chk("rst_init_done", int'(init_done), 0);
        chk("rst_busy", int'(busy), 1);
        chk("rst_err", int'(err), 0);
        chk("rst_err_code", int'(err_code), 0);
        chk("rst_err_chan", int'(err_chan), 0);
        chk("rst_cntvaluein", int'(cntvaluein), pack_taps(def_taps));

        // Power-up: RDY arrives 10 cycles after reset release
        @(negedge clk) rst = 1'b0;
        repeat (10) @(posedge clk);
        push_init(def_taps);
        #1 rdy_in = 1'b1;
        wait_init();
        chk("init_done", int'(init_done), 1);
        chk("init_err", int'(err), 0);
        chk("init_busy", int'(busy), 0);
        chk("init_ld_left", ld_q.size(), 0);

        // Set, read, back-to-back reads, inc
        push_ld(2, 7);
        send(OP_SET, 2, 7);
        wait_idle(lat);
        chk("set_latency", lat, EXP_LAT);
        rd_q.push_back(7);
        send(OP_READ, 2, 0);
        rd_q.push_back(7);
        rd_q.push_back(0);
        send_read2(2, 5);
        push_ld(2, 8);
        send(OP_INC, 2, 0);
        wait_idle(lat);
        chk("inc_latency", lat, EXP_LAT);

        // Saturation at both ends still loads
        push_ld(1, 31);
        send(OP_SET, 1, 31);
        wait_idle(lat);
        push_ld(1, 31);
        send(OP_INC, 1, 0);
        wait_idle(lat);
        rd_q.push_back(31);
        send(OP_READ, 1, 0);
        push_ld(0, 0);
        send(OP_SET, 0, 0);
        wait_idle(lat);
        push_ld(0, 0);
        send(OP_DEC, 0, 0);
        wait_idle(lat);
        chk("dec_sat_latency", lat, EXP_LAT);
        rd_q.push_back(0);
        send(OP_READ, 0, 0);
        push_ld(2, 7);
        send(OP_DEC, 2, 0);
        wait_idle(lat);
        repeat (2) @(posedge clk);
        #1 chk("mid_cntvaluein", int'(cntvaluein), pack_taps(mid_taps));

        // Bad channel: dropped, first error recorded
        send(OP_SET, 7, 9);
        send(OP_READ, 7, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("badch_err", int'(err), 1);
        chk("badch_code", int'(err_code), 1);
        chk("badch_chan", int'(err_chan), 7);
        chk("badch_busy", int'(busy), 0);
        chk("badch_cntvaluein", int'(cntvaluein), pack_taps(mid_taps));

        // Reset clears the error and restores defaults
        push_init(def_taps);
        @(negedge clk) rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst2_err", int'(err), 0);
        chk("rst2_init_done", int'(init_done), 0);
        @(negedge clk) rst = 1'b0;
        wait_init();
        chk("rst2_ld_left", ld_q.size(), 0);

        // Readback mismatch on lane 3
        hold3 = 1'b1;
        push_ld(3, 12);
        send(OP_SET, 3, 12);
        wait_idle(lat);
`ifdef IDELAY_TAP_VERIFY_EN
        chk("vfy_err", int'(err), 1);
        chk("vfy_code", int'(err_code), 2);
        chk("vfy_chan", int'(err_chan), 3);
`else
        chk("vfy_err", int'(err), 0);
        chk("vfy_code", int'(err_code), 0);
`endif
        hold3 = 1'b0;
        send(OP_INC, 6, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("late_err", int'(err), 1);
`ifdef IDELAY_TAP_VERIFY_EN
        chk("late_code", int'(err_code), 2);
        chk("late_chan", int'(err_chan), 3);
`else
        chk("late_code", int'(err_code), 1);
        chk("late_chan", int'(err_chan), 6);
`endif

        // RDY lost while lane 4 settles; re-init uses current shadows
        push_ld(4, 17);
        send(OP_SET, 4, 17);
        @(posedge clk);
        #1 rdy_in = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("drop_init_done", int'(init_done), 0);
        chk("drop_busy", int'(busy), 1);
        chk("drop_cfg_ready", int'(cfg_ready), 0);
        push_init(reload_taps);
        rdy_in = 1'b1;
        wait_init();
        chk("reinit_done", int'(init_done), 1);
        chk("reinit_busy", int'(busy), 0);
        chk("reinit_cntvaluein", int'(cntvaluein), pack_taps(reload_taps));
        chk("reinit_err", int'(err), 1);

        repeat (5) @(posedge clk);
        #1;
        chk("end_ld_left", ld_q.size(), 0);
        chk("end_rd_left", rd_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
